// File: rtl/alu_arb_pkg.sv
// Shared constants for the two-channel ALU arbiter: opcodes, FSM encoding, default width.
// No logic here; all timing and backpressure behaviour lives in alu_arbiter.
package alu_arb_pkg;

  localparam int W_DEFAULT = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_shared_alu.sv
// Shared arithmetic: combinational add/sub/mul (all-ones on divide by zero) plus a W-cycle restoring divider.
// Divider launches on start; done and div_result are valid during the last iteration cycle, so the caller latches on that edge.
module shared_alu
  import alu_arb_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  op_t            op,
  output logic           need_iter,
  output logic [2*W-1:0] result,
  output logic           done,
  output logic [2*W-1:0] div_result
);

  localparam int CW = $clog2(W);

  logic          active;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  dvs;
  logic [W:0]    trial;
  logic [W:0]    diff;
  logic [W-1:0]  rem_nxt;
  logic [W-1:0]  quo_nxt;

  assign need_iter = (op == OP_DIV) && (b != '0);

  always_comb begin
    result = '1;
    case (op)
      OP_ADD:  result = {{W{1'b0}}, a} + {{W{1'b0}}, b};
      OP_SUB:  result = {{W{1'b0}}, a} - {{W{1'b0}}, b};
      OP_MUL:  result = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      default: result = '1;
    endcase
  end

  // Quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  always_comb begin
    trial = {rem, quo[W-1]};
    diff  = trial - {1'b0, dvs};
    if (!diff[W]) begin
      rem_nxt = diff[W-1:0];
      quo_nxt = {quo[W-2:0], 1'b1};
    end else begin
      rem_nxt = trial[W-1:0];
      quo_nxt = {quo[W-2:0], 1'b0};
    end
  end

  assign done       = active && (cnt == CW'(W - 1));
  assign div_result = {rem_nxt, quo_nxt};

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      rem    <= '0;
      quo    <= a;
      dvs    <= b;
    end else if (active) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-channel round-robin front end to one shared ALU; ack one cycle after grant, result 2 cycles (div W+2) after sample.
// One op in flight; requests wait (held by requester) while busy or while i_hold is high.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_req1,
  input  logic           i_req2,
  input  logic [W-1:0]   i_a1,
  input  logic [W-1:0]   i_b1,
  input  logic [W-1:0]   i_a2,
  input  logic [W-1:0]   i_b2,
  input  logic [1:0]     i_op1,
  input  logic [1:0]     i_op2,
  input  logic           i_hold,
  output logic           o_ack1,
  output logic           o_ack2,
  output logic [2*W-1:0] o_r1,
  output logic [2*W-1:0] o_r2,
  output logic           o_valid1,
  output logic           o_valid2,
  output logic           o_busy
);

  state_t         state;
  logic           ptr;      // 0: channel 1 wins a tie, 1: channel 2 wins
  logic           ch;       // channel being served, 0 = ch1
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  op_t            op_q;
  logic           grant2;
  logic           need_iter;
  logic           alu_start;
  logic           div_done;
  logic [2*W-1:0] alu_result;
  logic [2*W-1:0] div_result;
  logic           fin;
  logic [2*W-1:0] fin_val;

  assign grant2    = i_req2 && (!i_req1 || ptr);
  assign alu_start = (state == ST_EXEC) && need_iter;
  assign fin       = ((state == ST_EXEC) && !need_iter) || ((state == ST_DIV) && div_done);
  assign fin_val   = (state == ST_DIV) ? div_result : alu_result;
  assign o_busy    = (state != ST_IDLE);

  shared_alu #(.W(W)) u_alu (
    .clk        (i_clk),
    .rst        (i_rst),
    .start      (alu_start),
    .a          (a_q),
    .b          (b_q),
    .op         (op_q),
    .need_iter  (need_iter),
    .result     (alu_result),
    .done       (div_done),
    .div_result (div_result)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      ptr      <= 1'b0;
      ch       <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      o_ack1   <= 1'b0;
      o_ack2   <= 1'b0;
      o_valid1 <= 1'b0;
      o_valid2 <= 1'b0;
      o_r1     <= '0;
      o_r2     <= '0;
    end else begin
      o_ack1   <= 1'b0;
      o_ack2   <= 1'b0;
      o_valid1 <= 1'b0;
      o_valid2 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!i_hold && (i_req1 || i_req2)) begin
            ch     <= grant2;
            a_q    <= grant2 ? i_a2 : i_a1;
            b_q    <= grant2 ? i_b2 : i_b1;
            op_q   <= op_t'(grant2 ? i_op2 : i_op1);
            o_ack1 <= !grant2;
            o_ack2 <= grant2;
            ptr    <= !grant2;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (need_iter) state <= ST_DIV;
        end
        ST_DIV: ;
        default: state <= ST_IDLE;
      endcase
      if (fin) begin
        if (ch) begin
          o_r2     <= fin_val;
          o_valid2 <= 1'b1;
        end else begin
          o_r1     <= fin_val;
          o_valid1 <= 1'b1;
        end
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter (W=16): arbitration order, op results, latencies, hold and reset.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req1, req2;
  logic [15:0] a1, b1, a2, b2;
  logic [1:0]  op1, op2;
  logic        hold;
  logic        ack1, ack2;
  logic [31:0] r1, r2;
  logic        valid1, valid2;
  logic        busy;

  int vec = 0;
  int err = 0;

  alu_arbiter #(.W(16)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req1   (req1),
    .i_req2   (req2),
    .i_a1     (a1),
    .i_b1     (b1),
    .i_a2     (a2),
    .i_b2     (b2),
    .i_op1    (op1),
    .i_op2    (op2),
    .i_hold   (hold),
    .o_ack1   (ack1),
    .o_ack2   (ack2),
    .o_r1     (r1),
    .o_r2     (r2),
    .o_valid1 (valid1),
    .o_valid2 (valid2),
    .o_busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    req1 = 0; req2 = 0; hold = 0;
    a1 = 0; b1 = 0; a2 = 0; b2 = 0; op1 = 0; op2 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; clear_inputs();
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); req1 = 1; a1 = 5; b1 = 5;
    repeat (2) @(negedge clk);
    vec++; if (ack1 !== 1'b0) begin err++; $display("FAIL reset_ack1 got %b want 0", ack1); end
    vec++; if (ack2 !== 1'b0) begin err++; $display("FAIL reset_ack2 got %b want 0", ack2); end
    vec++; if (valid1 !== 1'b0 || valid2 !== 1'b0) begin err++; $display("FAIL reset_valid got %b%b want 00", valid1, valid2); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (r1 !== 32'd0 || r2 !== 32'd0) begin err++; $display("FAIL reset_results got %h/%h want 0/0", r1, r2); end
    rst = 0; req1 = 0;
  endtask

  task automatic test_add();
    @(negedge clk); a1 = 25; b1 = 4; op1 = 0; req1 = 1;
    @(negedge clk);
    vec++; if (ack1 !== 1'b1 || ack2 !== 1'b0) begin err++; $display("FAIL add_ack got %b%b want 10", ack1, ack2); end
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL add_busy got %b want 1", busy); end
    req1 = 0;
    @(negedge clk);
    vec++; if (valid1 !== 1'b1 || valid2 !== 1'b0) begin err++; $display("FAIL add_valid got %b%b want 10", valid1, valid2); end
    vec++; if (r1 !== 32'd29) begin err++; $display("FAIL add_r1 got %0d want 29", r1); end
    vec++; if (r2 !== 32'd0) begin err++; $display("FAIL add_r2_hold got %0d want 0", r2); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL add_idle got %b want 0", busy); end
  endtask

  task automatic test_arbitration();
    do_reset();
    a1 = 25; b1 = 4; op1 = 2; req1 = 1;
    a2 = 10; b2 = 3; op2 = 1; req2 = 1;
    @(negedge clk);
    vec++; if (ack1 !== 1'b1 || ack2 !== 1'b0) begin err++; $display("FAIL pair1_ack got %b%b want 10", ack1, ack2); end
    req1 = 0;
    @(negedge clk);
    vec++; if (valid1 !== 1'b1 || valid2 !== 1'b0 || r1 !== 32'd100) begin err++; $display("FAIL pair1_r1 got v=%b%b r1=%0d want v=10 r1=100", valid1, valid2, r1); end
    @(negedge clk);
    vec++; if (ack2 !== 1'b1 || ack1 !== 1'b0) begin err++; $display("FAIL pair1_ack2_no_gap got %b%b want 01", ack1, ack2); end
    req2 = 0;
    @(negedge clk);
    vec++; if (valid2 !== 1'b1 || valid1 !== 1'b0 || r2 !== 32'd7) begin err++; $display("FAIL pair1_r2 got v=%b%b r2=%0d want v=01 r2=7", valid1, valid2, r2); end
    a1 = 1; b1 = 2; op1 = 0; req1 = 1;
    a2 = 5; b2 = 5; op2 = 0; req2 = 1;
    @(negedge clk);
    vec++; if (ack1 !== 1'b1 || ack2 !== 1'b0) begin err++; $display("FAIL pair2_ptr_ch1 got %b%b want 10", ack1, ack2); end
    req1 = 0;
    @(negedge clk);
    vec++; if (valid1 !== 1'b1 || r1 !== 32'd3) begin err++; $display("FAIL pair2_r1 got v=%b r1=%0d want v=1 r1=3", valid1, r1); end
    a1 = 7; b1 = 6; op1 = 2; req1 = 1;
    @(negedge clk);
    vec++; if (ack2 !== 1'b1 || ack1 !== 1'b0) begin err++; $display("FAIL pair3_ptr_ch2 got %b%b want 01", ack1, ack2); end
    req2 = 0;
    @(negedge clk);
    vec++; if (valid2 !== 1'b1 || r2 !== 32'd10 || r1 !== 32'd3) begin err++; $display("FAIL pair3_r2 got v=%b r2=%0d r1=%0d want v=1 r2=10 r1=3", valid2, r2, r1); end
    @(negedge clk);
    vec++; if (ack1 !== 1'b1) begin err++; $display("FAIL pair3_ack1 got %b want 1", ack1); end
    req1 = 0;
    @(negedge clk);
    vec++; if (valid1 !== 1'b1 || r1 !== 32'd42) begin err++; $display("FAIL pair3_r1 got v=%b r1=%0d want v=1 r1=42", valid1, r1); end
  endtask

  task automatic test_sub_negative();
    @(negedge clk); a2 = 3; b2 = 10; op2 = 1; req2 = 1;
    @(negedge clk);
    vec++; if (ack2 !== 1'b1) begin err++; $display("FAIL sub_ack2 got %b want 1", ack2); end
    req2 = 0;
    @(negedge clk);
    vec++; if (valid2 !== 1'b1 || r2 !== 32'hFFFF_FFF9) begin err++; $display("FAIL sub_r2 got v=%b r2=%h want v=1 r2=fffffff9", valid2, r2); end
    vec++; if (r1 !== 32'd42) begin err++; $display("FAIL sub_r1_hold got %0d want 42", r1); end
  endtask

  task automatic test_div();
    int lat;
    bit busy_ok;
    @(negedge clk); a1 = 25; b1 = 4; op1 = 3; req1 = 1;
    lat = 0; busy_ok = 1;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        vec++; if (ack1 !== 1'b1) begin err++; $display("FAIL div_ack1 got %b want 1", ack1); end
        req1 = 0;
      end
      if (valid1 === 1'b1) lat = k;
      else if (busy !== 1'b1) busy_ok = 0;
    end
    vec++; if (lat !== 18) begin err++; $display("FAIL div_latency got %0d want 18", lat); end
    vec++; if (busy_ok !== 1'b1) begin err++; $display("FAIL div_busy got %b want 1", busy_ok); end
    vec++; if (r1 !== 32'h0001_0006) begin err++; $display("FAIL div_r1 got %h want 00010006", r1); end
  endtask

  task automatic test_div_zero();
    int lat;
    @(negedge clk); a1 = 25; b1 = 0; op1 = 3; req1 = 1;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) req1 = 0;
      if (valid1 === 1'b1) lat = k;
    end
    vec++; if (lat !== 2) begin err++; $display("FAIL div0_latency got %0d want 2", lat); end
    vec++; if (r1 !== 32'hFFFF_FFFF) begin err++; $display("FAIL div0_r1 got %h want ffffffff", r1); end
  endtask

  task automatic test_reset_mid_div();
    bit seen;
    @(negedge clk); a1 = 100; b1 = 7; op1 = 3; req1 = 1;
    @(negedge clk); req1 = 0;
    repeat (5) @(negedge clk);
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL middiv_busy got %b want 1", busy); end
    rst = 1; req2 = 1; a2 = 1; b2 = 1; op2 = 0;
    @(negedge clk);
    rst = 0; req2 = 0;
    vec++; if (busy !== 1'b0 || r1 !== 32'd0 || r2 !== 32'd0) begin err++; $display("FAIL middiv_reset got busy=%b r1=%h r2=%h want 0/0/0", busy, r1, r2); end
    vec++; if (ack2 !== 1'b0 || valid1 !== 1'b0) begin err++; $display("FAIL middiv_override got ack2=%b valid1=%b want 0/0", ack2, valid1); end
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (valid1 !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    vec++; if (seen !== 1'b0) begin err++; $display("FAIL middiv_abandon got activity=%b want 0", seen); end
  endtask

  task automatic test_hold();
    bit seen;
    int lat;
    @(negedge clk); hold = 1;
    a1 = 9;  b1 = 9; op1 = 0; req1 = 1;
    a2 = 20; b2 = 5; op2 = 3; req2 = 1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack1 !== 1'b0 || ack2 !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    vec++; if (seen !== 1'b0) begin err++; $display("FAIL hold_block got activity=%b want 0", seen); end
    hold = 0;
    @(negedge clk);
    vec++; if (ack1 !== 1'b1 || ack2 !== 1'b0) begin err++; $display("FAIL hold_release_ack got %b%b want 10", ack1, ack2); end
    req1 = 0; hold = 1;
    @(negedge clk);
    vec++; if (valid1 !== 1'b1 || r1 !== 32'd18) begin err++; $display("FAIL hold_midop got v=%b r1=%0d want v=1 r1=18", valid1, r1); end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack2 !== 1'b0) seen = 1;
    end
    vec++; if (seen !== 1'b0) begin err++; $display("FAIL hold_ch2_wait got ack=%b want 0", seen); end
    hold = 0;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) req2 = 0;
      if (valid2 === 1'b1) lat = k;
    end
    vec++; if (lat !== 18 || r2 !== 32'h0000_0004) begin err++; $display("FAIL hold_ch2_div got lat=%0d r2=%h want lat=18 r2=00000004", lat, r2); end
    vec++; if (r1 !== 32'd18) begin err++; $display("FAIL hold_r1_hold got %0d want 18", r1); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_arbitration();
    test_sub_negative();
    test_div();
    test_div_zero();
    test_reset_mid_div();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
